// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a combinational IMEM and fills the
// IF/ID register, with decoder back-pressure, EX redirects and fault halting.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] IF_PC,
  input  logic [31:0] IF_instruction,
  input  logic        EX_redirect_valid,
  input  logic [31:0] EX_redirect_target,
  input  logic        ID_ready,
  output logic        ID_valid,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [31:0] WORDS_LIMIT = 32'(IMEM_WORDS);

  state_t      state_reg, state_next;
  logic [31:0] pc_next, id_instruction_next, id_pc_next, fault_pc_next, count_next;
  logic        id_valid_next, fault_next;
  logic        accepted, pc_ok;

  assign accepted    = !ID_valid || ID_ready;
  assign pc_ok       = (IF_PC[1:0] == 2'b00) && ({2'b00, IF_PC[31:2]} < WORDS_LIMIT);
  assign ID_PC_plus4 = ID_PC + 32'd4;

  always_comb begin
    state_next          = state_reg;
    pc_next             = IF_PC;
    id_valid_next       = ID_valid;
    id_instruction_next = ID_instruction;
    id_pc_next          = ID_PC;
    fault_next          = fetch_fault;
    fault_pc_next       = fetch_fault_pc;
    count_next          = fetch_count;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
        if (EX_redirect_valid) pc_next = EX_redirect_target;
      end
      RUN: begin
        // Redirect flushes the wrong-path instruction even if the decoder is stalled.
        if (EX_redirect_valid) begin
          pc_next       = EX_redirect_target;
          id_valid_next = 1'b0;
        end else if (accepted) begin
          if (pc_ok) begin
            id_instruction_next = IF_instruction;
            id_pc_next          = IF_PC;
            id_valid_next       = 1'b1;
            pc_next             = IF_PC + 32'd4;
            count_next          = fetch_count + 32'd1;
          end else begin
            id_valid_next = 1'b0;
            fault_next    = 1'b1;
            fault_pc_next = IF_PC;
            state_next    = HALT;
          end
        end
      end
      HALT: begin
        if (EX_redirect_valid) begin
          pc_next       = EX_redirect_target;
          id_valid_next = 1'b0;
          fault_next    = 1'b0;
          state_next    = RUN;
        end else if (ID_valid && ID_ready) begin
          id_valid_next = 1'b0;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= BOOT;
      IF_PC          <= RESET_PC;
      ID_valid       <= 1'b0;
      ID_instruction <= 32'd0;
      ID_PC          <= 32'd0;
      fetch_fault    <= 1'b0;
      fetch_fault_pc <= 32'd0;
      fetch_count    <= 32'd0;
    end else begin
      state_reg      <= state_next;
      IF_PC          <= pc_next;
      ID_valid       <= id_valid_next;
      ID_instruction <= id_instruction_next;
      ID_PC          <= id_pc_next;
      fetch_fault    <= fault_next;
      fetch_fault_pc <= fault_pc_next;
      fetch_count    <= count_next;
    end
  end

endmodule
